// File: rtl/sys_reg_commit.sv
// Commits execute-stage PSR/IDTR writes, then runs the IDT reload handshake
// and the fetch flush. Execute stays locked until the whole sequence is done.
module sys_reg_commit #(
  parameter logic [31:0] PSR_RESET   = 32'h0000_0000,
  parameter logic [31:0] IDTR_RESET  = 32'h0000_0000,
  parameter int unsigned PSR_IM_BIT  = 2,
  parameter int unsigned IDT_TIMEOUT = 255
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iEXE_VALID,
  input  logic        iEXE_PSR_VALID,
  input  logic        iEXE_IDT_VALID,
  input  logic [31:0] iEXE_DATA,
  input  logic [31:0] iEXE_RELOAD_ADDR,
  output logic        oEXE_LOCK,
  output logic [31:0] oPSR,
  output logic [31:0] oIDTR,
  output logic        oIRQ_MASK,
  output logic        oIDT_LOAD_REQ,
  input  logic        iIDT_LOAD_DONE,
  output logic        oIDT_ERR,
  output logic        oFLUSH_REQ,
  output logic [31:0] oFLUSH_ADDR,
  input  logic        iFLUSH_ACK
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IDT_LOAD = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  // Counter value on which an unanswered IDT reload is abandoned.
  localparam logic [7:0] TIMEOUT_LAST = 8'(IDT_TIMEOUT - 1);

  state_t      state_reg;
  logic [31:0] psr_reg;
  logic [31:0] idtr_reg;
  logic [31:0] flush_addr_reg;
  logic [7:0]  timeout_cnt_reg;
  logic        idt_err_reg;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_reg       <= IDLE;
      psr_reg         <= PSR_RESET;
      idtr_reg        <= IDTR_RESET;
      flush_addr_reg  <= 32'h0000_0000;
      timeout_cnt_reg <= 8'd0;
      idt_err_reg     <= 1'b0;
    end else begin
      idt_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (iEXE_VALID) begin
            if (iEXE_PSR_VALID) psr_reg  <= iEXE_DATA;
            if (iEXE_IDT_VALID) idtr_reg <= iEXE_DATA;
            if (iEXE_PSR_VALID || iEXE_IDT_VALID) flush_addr_reg <= iEXE_RELOAD_ADDR;
            // An IDT write always reloads the table before the flush.
            if (iEXE_IDT_VALID) begin
              state_reg       <= IDT_LOAD;
              timeout_cnt_reg <= 8'd0;
            end else if (iEXE_PSR_VALID) begin
              state_reg <= FLUSH;
            end
          end
        end
        IDT_LOAD: begin
          if (iIDT_LOAD_DONE) begin
            state_reg <= FLUSH;
          end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
            idt_err_reg <= 1'b1;
            state_reg   <= FLUSH;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 8'd1;
          end
        end
        FLUSH: begin
          if (iFLUSH_ACK) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign oEXE_LOCK     = (state_reg != IDLE);
  assign oIDT_LOAD_REQ = (state_reg == IDT_LOAD);
  assign oFLUSH_REQ    = (state_reg == FLUSH);
  assign oPSR          = psr_reg;
  assign oIDTR         = idtr_reg;
  assign oIRQ_MASK     = psr_reg[PSR_IM_BIT];
  assign oFLUSH_ADDR   = flush_addr_reg;
  assign oIDT_ERR      = idt_err_reg;

endmodule

// File: tb/tb_sys_reg_commit.sv
// Bench for sys_reg_commit: directed vector table, corner sequences and a
// randomized run checked against a per-transaction timeline model.
module tb_sys_reg_commit;

  localparam logic [31:0] PSR_R   = 32'h1234_5670;
  localparam logic [31:0] IDTR_R  = 32'hDEAD_0000;
  localparam int          T_MAIN  = 8;
  localparam int          T_SHORT = 4;

  logic iCLOCK  = 1'b0;
  logic inRESET = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  logic        exe_valid, exe_psr_v, exe_idt_v, idt_done, flush_ack;
  logic [31:0] exe_data, exe_addr;
  logic        exe_lock, irq_mask, idt_req, idt_err, flush_req;
  logic [31:0] psr, idtr, flush_addr;

  logic        t_valid, t_psr_v, t_idt_v, t_done, t_ack;
  logic [31:0] t_data, t_addr;
  logic        t_lock, t_mask, t_idt_req, t_err, t_flush_req;
  logic [31:0] t_psr, t_idtr, t_flush_addr;

  sys_reg_commit #(
    .PSR_RESET(PSR_R), .IDTR_RESET(IDTR_R), .PSR_IM_BIT(2), .IDT_TIMEOUT(T_MAIN)
  ) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET),
    .iEXE_VALID(exe_valid), .iEXE_PSR_VALID(exe_psr_v), .iEXE_IDT_VALID(exe_idt_v),
    .iEXE_DATA(exe_data), .iEXE_RELOAD_ADDR(exe_addr),
    .oEXE_LOCK(exe_lock), .oPSR(psr), .oIDTR(idtr), .oIRQ_MASK(irq_mask),
    .oIDT_LOAD_REQ(idt_req), .iIDT_LOAD_DONE(idt_done), .oIDT_ERR(idt_err),
    .oFLUSH_REQ(flush_req), .oFLUSH_ADDR(flush_addr), .iFLUSH_ACK(flush_ack)
  );

  sys_reg_commit #(
    .PSR_RESET(32'h0), .IDTR_RESET(32'h0), .PSR_IM_BIT(2), .IDT_TIMEOUT(T_SHORT)
  ) dut_t (
    .iCLOCK(iCLOCK), .inRESET(inRESET),
    .iEXE_VALID(t_valid), .iEXE_PSR_VALID(t_psr_v), .iEXE_IDT_VALID(t_idt_v),
    .iEXE_DATA(t_data), .iEXE_RELOAD_ADDR(t_addr),
    .oEXE_LOCK(t_lock), .oPSR(t_psr), .oIDTR(t_idtr), .oIRQ_MASK(t_mask),
    .oIDT_LOAD_REQ(t_idt_req), .iIDT_LOAD_DONE(t_done), .oIDT_ERR(t_err),
    .oFLUSH_REQ(t_flush_req), .oFLUSH_ADDR(t_flush_addr), .iFLUSH_ACK(t_ack)
  );

  typedef struct {
    logic        psr_v;
    logic        idt_v;
    logic [31:0] data;
    logic [31:0] addr;
    int          d;          // IDT_LOAD cycle on which done is raised
    int          a;          // FLUSH cycle on which ack is raised
    logic [31:0] exp_psr;
    logic [31:0] exp_idtr;
    logic        exp_mask;
    int          exp_idt;
    int          exp_flush;
    int          exp_lock;
    int          exp_err;
  } vec_t;

  vec_t vecs[8];
  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic check_ctl(input string tag, input logic lk, input logic ir,
                           input logic fr, input logic er);
    check({tag, ".lock"},      32'(exe_lock),  32'(lk));
    check({tag, ".idt_req"},   32'(idt_req),   32'(ir));
    check({tag, ".flush_req"}, 32'(flush_req), 32'(fr));
    check({tag, ".idt_err"},   32'(idt_err),   32'(er));
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n_idt, n_fl, n_lock, n_err;
    n_idt = 0; n_fl = 0; n_lock = 0; n_err = 0;
    exe_valid = 1'b1; exe_psr_v = v.psr_v; exe_idt_v = v.idt_v;
    exe_data = v.data; exe_addr = v.addr;
    tick();
    exe_valid = 1'b0; exe_psr_v = 1'b0; exe_idt_v = 1'b0;
    check("vec.psr", psr, v.exp_psr);
    check("vec.idtr", idtr, v.exp_idtr);
    check("vec.irq_mask", 32'(irq_mask), 32'(v.exp_mask));
    for (int c = 0; c < 64 && exe_lock; c++) begin
      n_lock++;
      if (idt_req) n_idt++;
      if (idt_err) n_err++;
      if (flush_req) begin
        n_fl++;
        check("vec.flush_addr", flush_addr, v.addr);
      end
      idt_done  = idt_req && (n_idt == v.d);
      flush_ack = flush_req && (n_fl == v.a);
      tick();
    end
    idt_done = 1'b0; flush_ack = 1'b0;
    check_ctl("vec.end", 1'b0, 1'b0, 1'b0, 1'b0);
    check("vec.idt_cycles", n_idt, v.exp_idt);
    check("vec.flush_cycles", n_fl, v.exp_flush);
    check("vec.lock_cycles", n_lock, v.exp_lock);
    check("vec.err_pulses", n_err, v.exp_err);
    $display("[TB] vec %0d: idt=%0d flush=%0d lock=%0d err=%0d", idx, n_idt, n_fl, n_lock, n_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] m_psr, m_idtr, m_addr;
    logic        pv, iv, to;
    int          d, a, len_idt, len_fl, cnt;

    exe_valid = 0; exe_psr_v = 0; exe_idt_v = 0; exe_data = 0; exe_addr = 0;
    idt_done = 0; flush_ack = 0;
    t_valid = 0; t_psr_v = 0; t_idt_v = 0; t_data = 0; t_addr = 0; t_done = 0; t_ack = 0;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_1008, 0, 3, 32'h0000_0004, IDTR_R, 1'b1, 0, 3, 3, 0};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_8000, 32'h0000_2000, 5, 1, 32'h0000_0004, 32'h0000_8000, 1'b1, 5, 1, 6, 0};
    vecs[2] = '{1'b1, 1'b1, 32'hA5A5_0000, 32'h0000_3004, 2, 2, 32'hA5A5_0000, 32'hA5A5_0000, 1'b0, 2, 2, 4, 0};
    vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_5555, 0, 0, 32'hA5A5_0000, 32'hA5A5_0000, 1'b0, 0, 0, 0, 0};
    vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_4000, 0, 1, 32'hFFFF_FFFF, 32'hA5A5_0000, 1'b1, 0, 1, 1, 0};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_1234, 32'h0000_4004, 1, 1, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1, 1, 2, 0};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_0040, 32'h0000_4008, 8, 1, 32'hFFFF_FFFF, 32'h0000_0040, 1'b1, 8, 1, 9, 0};
    vecs[7] = '{1'b0, 1'b1, 32'h0000_0080, 32'h0000_400C, 9, 2, 32'hFFFF_FFFF, 32'h0000_0080, 1'b1, 8, 2, 10, 1};

    // Reset and idle state.
    repeat (3) @(posedge iCLOCK);
    @(negedge iCLOCK);
    inRESET = 1'b1;
    tick();
    check_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.psr", psr, PSR_R);
    check("reset.idtr", idtr, IDTR_R);
    check("reset.irq_mask", 32'(irq_mask), 32'd0);
    check("reset.flush_addr", flush_addr, 32'h0);
    check("reset.t_psr", t_psr, 32'h0);
    check("reset.t_lock", 32'(t_lock), 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Non-sysreg results held for several cycles never lock execute.
    exe_valid = 1'b1; exe_data = 32'h0BAD_0BAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold.lock", 32'(exe_lock), 32'd0);
      check("hold.psr", psr, 32'hFFFF_FFFF);
      check("hold.idtr", idtr, 32'h0000_0080);
    end
    $display("[TB] held non-sysreg result for 3 cycles");

    // Back-to-back PSR writes: second lands only after the first flush ack.
    exe_psr_v = 1'b1; exe_data = 32'h0000_0011; exe_addr = 32'h0000_0100;
    tick();
    exe_data = 32'h0000_0022; exe_addr = 32'h0000_0200;
    check("b2b.psr1", psr, 32'h0000_0011);
    check("b2b.flush_req1", 32'(flush_req), 32'd1);
    tick();
    flush_ack = 1'b1;
    check("b2b.psr_hold", psr, 32'h0000_0011);
    check("b2b.addr_hold", flush_addr, 32'h0000_0100);
    tick();
    flush_ack = 1'b0;
    check("b2b.idle_lock", 32'(exe_lock), 32'd0);
    check("b2b.idle_psr", psr, 32'h0000_0011);
    tick();
    exe_valid = 1'b0; exe_psr_v = 1'b0; flush_ack = 1'b1;
    check("b2b.psr2", psr, 32'h0000_0022);
    check("b2b.addr2", flush_addr, 32'h0000_0200);
    check("b2b.lock2", 32'(exe_lock), 32'd1);
    tick();
    flush_ack = 1'b0;
    check("b2b.end_lock", 32'(exe_lock), 32'd0);
    $display("[TB] back-to-back PSR writes done");

    // IDT reload timeout on the short-timeout instance.
    t_valid = 1'b1; t_idt_v = 1'b1; t_data = 32'h0000_0100; t_addr = 32'h0000_0600;
    tick();
    t_valid = 1'b0; t_idt_v = 1'b0;
    check("tmo.idtr", t_idtr, 32'h0000_0100);
    cnt = 0;
    for (int c = 0; c < 20 && t_idt_req; c++) begin
      cnt++;
      check("tmo.err_early", 32'(t_err), 32'd0);
      tick();
    end
    check("tmo.idt_cycles", cnt, T_SHORT);
    check("tmo.err_pulse", 32'(t_err), 32'd1);
    check("tmo.flush_req", 32'(t_flush_req), 32'd1);
    check("tmo.flush_addr", t_flush_addr, 32'h0000_0600);
    tick();
    check("tmo.err_one_cycle", 32'(t_err), 32'd0);
    check("tmo.flush_req2", 32'(t_flush_req), 32'd1);
    t_ack = 1'b1;
    tick();
    t_ack = 1'b0;
    check("tmo.end_lock", 32'(t_lock), 32'd0);
    $display("[TB] IDT timeout sequence done");

    // Asynchronous reset in the middle of a flush.
    exe_valid = 1'b1; exe_psr_v = 1'b1; exe_data = 32'hCAFE_0004; exe_addr = 32'h0000_7000;
    tick();
    exe_valid = 1'b0; exe_psr_v = 1'b0;
    check("rst_mid.flush_before", 32'(flush_req), 32'd1);
    #2 inRESET = 1'b0;
    #1;
    check_ctl("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_mid.psr", psr, PSR_R);
    check("rst_mid.flush_addr", flush_addr, 32'h0);
    #2 inRESET = 1'b1;
    tick();
    flush_ack = 1'b1;
    check_ctl("rst_after", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    flush_ack = 1'b0;
    check("rst_after.lock2", 32'(exe_lock), 32'd0);
    $display("[TB] reset during flush done");

    // Randomized transactions against the timeline model.
    m_psr = PSR_R; m_idtr = IDTR_R; m_addr = 32'h0;
    for (int n = 0; n < 50; n++) begin
      pv = 1'($urandom_range(0, 1));
      iv = 1'($urandom_range(0, 1));
      d  = $urandom_range(1, T_MAIN + 2);
      a  = $urandom_range(1, 4);
      exe_valid = 1'b1; exe_psr_v = pv; exe_idt_v = iv;
      exe_data = $urandom; exe_addr = $urandom;
      idt_done = 1'($urandom_range(0, 1));
      flush_ack = 1'($urandom_range(0, 1));
      if (pv) m_psr = exe_data;
      if (iv) m_idtr = exe_data;
      if (pv || iv) m_addr = exe_addr;
      len_idt = iv ? ((d <= T_MAIN) ? d : T_MAIN) : 0;
      to      = iv && (d > T_MAIN);
      len_fl  = (pv || iv) ? a : 0;
      tick();
      for (int k = 1; k <= len_idt + len_fl; k++) begin
        check_ctl("rnd", 1'b1, k <= len_idt, k > len_idt, to && (k == len_idt + 1));
        check("rnd.psr", psr, m_psr);
        check("rnd.idtr", idtr, m_idtr);
        if (k > len_idt) check("rnd.flush_addr", flush_addr, m_addr);
        exe_valid = 1'($urandom_range(0, 1));
        exe_psr_v = 1'($urandom_range(0, 1));
        exe_idt_v = 1'($urandom_range(0, 1));
        exe_data  = $urandom; exe_addr = $urandom;
        idt_done  = (k <= len_idt) ? (k == d) : 1'($urandom_range(0, 1));
        flush_ack = (k > len_idt) ? (k - len_idt == a) : 1'($urandom_range(0, 1));
        tick();
      end
      check_ctl("rnd.idle", 1'b0, 1'b0, 1'b0, 1'b0);
      check("rnd.idle_psr", psr, m_psr);
      check("rnd.idle_idtr", idtr, m_idtr);
      check("rnd.idle_mask", 32'(irq_mask), 32'(m_psr[2]));
      check("rnd.idle_addr", flush_addr, m_addr);
      $display("[TB] rnd %0d: psr_v=%0b idt_v=%0b idt=%0d flush=%0d timeout=%0b",
               n, pv, iv, len_idt, len_fl, to);
    end
    exe_valid = 1'b0; exe_psr_v = 1'b0; exe_idt_v = 1'b0; idt_done = 1'b0; flush_ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sys_reg_commit.md
Name: sys_reg_commit

Overview:
- Write-back end of the system-register path. Takes the PSR/IDT write results from the execute stage and commits them into the architectural PSR and IDTR.
- After an IDT write, sequences the IDT-table reload handshake with the interrupt controller.
- After any system-register write, issues a pipeline flush/reload to fetch at the supplied address.
- Stalls execute until the whole sequence completes.

Parameters:
- PSR_RESET, 32'h0000_0000, PSR value after reset.
- IDTR_RESET, 32'h0000_0000, IDTR value after reset.
- PSR_IM_BIT, 2, PSR bit index exported as the interrupt mask.
- IDT_TIMEOUT, 255, maximum cycles spent waiting for iIDT_LOAD_DONE; range 1..255, held in an 8-bit counter.

Ports:
- iCLOCK  in  1  clock; all state changes on rising edge.
- inRESET  in  1  asynchronous active-low reset.
- iEXE_VALID  in  1  execute result valid; held by execute while oEXE_LOCK=1.
- iEXE_PSR_VALID  in  1  result is a PSR write.
- iEXE_IDT_VALID  in  1  result is an IDTR write.
- iEXE_DATA  in  32  value to write.
- iEXE_RELOAD_ADDR  in  32  fetch restart address (PC of next instruction).
- oEXE_LOCK  out  1  stall to execute.
- oPSR  out  32  committed PSR.
- oIDTR  out  32  committed IDTR.
- oIRQ_MASK  out  1  oPSR[PSR_IM_BIT].
- oIDT_LOAD_REQ  out  1  level request to the interrupt controller to reload the IDT from oIDTR.
- iIDT_LOAD_DONE  in  1  IDT reload complete.
- oIDT_ERR  out  1  one-cycle pulse: IDT reload timed out.
- oFLUSH_REQ  out  1  level flush/reload request to fetch.
- oFLUSH_ADDR  out  32  reload address, stable while oFLUSH_REQ=1.
- iFLUSH_ACK  in  1  fetch accepted the flush.

Behaviour:
- Reset (async, inRESET=0):
  - state=IDLE.
  - oPSR=PSR_RESET, oIDTR=IDTR_RESET.
  - oEXE_LOCK, oIDT_LOAD_REQ, oIDT_ERR, oFLUSH_REQ all 0.
  - oFLUSH_ADDR=0, timeout counter=0.
  - Reset mid-sequence aborts it. No ack or done is expected afterwards.
- States: IDLE, IDT_LOAD, FLUSH.
- oEXE_LOCK = (state != IDLE), decoded combinationally from the state register.
- oIDT_LOAD_REQ = (state == IDT_LOAD).
- oFLUSH_REQ = (state == FLUSH).
- Accept condition: iEXE_VALID && state==IDLE. On an accepting edge:
  - If iEXE_PSR_VALID: oPSR <= iEXE_DATA.
  - If iEXE_IDT_VALID: oIDTR <= iEXE_DATA.
  - If either flag is set: oFLUSH_ADDR <= iEXE_RELOAD_ADDR.
  - Next state:
    - IDT_VALID set (with or without PSR_VALID): IDT_LOAD, counter cleared.
    - Only PSR_VALID set: FLUSH.
    - Neither flag set: stay IDLE, no register change. Execute is never locked for non-sysreg results.
- Both flags set in the same cycle: both registers take iEXE_DATA, then the full IDT_LOAD -> FLUSH sequence runs.
- Latency: a write accepted in cycle N is visible on oPSR/oIDTR/oIRQ_MASK in cycle N+1. oEXE_LOCK rises in N+1.
- IDT_LOAD:
  - iIDT_LOAD_DONE=1: go to FLUSH.
  - Otherwise the counter increments each cycle. When the counter reaches IDT_TIMEOUT-1 without done: pulse oIDT_ERR for one cycle (the transition cycle's next cycle) and go to FLUSH.
  - Done and timeout in the same cycle: done wins, no error.
- FLUSH: oFLUSH_REQ and oFLUSH_ADDR are held until a cycle with iFLUSH_ACK=1, then return to IDLE. oEXE_LOCK falls the following cycle.
  - An ack in the first FLUSH cycle is valid, giving a minimum 1-cycle flush.
- Minimum lock duration:
  - PSR-only write: 1 cycle.
  - IDT write: 2 cycles.
- iFLUSH_ACK outside FLUSH and iIDT_LOAD_DONE outside IDT_LOAD are ignored.
- iEXE_* inputs are ignored while state != IDLE. Execute holds the next instruction, which is accepted on the first IDLE cycle.
- No width conversion: data and addresses pass through unmodified at 32 bits.

Test Plan:
- Reset then idle: oPSR=PSR_RESET, oIDTR=IDTR_RESET, all request and lock outputs 0. Drive inRESET low mid-FLUSH -> oFLUSH_REQ drops immediately, state returns to IDLE.
- PSR write: iEXE_DATA=32'h0000_0004, reload addr 32'h0000_1008, ack on the 3rd FLUSH cycle.
  - Next cycle: oPSR=4 and oIRQ_MASK=1.
  - oFLUSH_ADDR=32'h1008, held with oFLUSH_REQ for 3 cycles.
  - oEXE_LOCK high for exactly 3 cycles.
- IDT write: iEXE_DATA=32'h0000_8000, done after 5 cycles -> oIDTR=32'h8000, oIDT_LOAD_REQ high for 5 cycles, then FLUSH, no oIDT_ERR.
- IDT timeout: IDT_TIMEOUT=4, done never asserted -> oIDT_LOAD_REQ high for 4 cycles, one-cycle oIDT_ERR pulse, then FLUSH.
- Both flags set with iEXE_DATA=32'hA5A5_0000 -> oPSR=oIDTR=32'hA5A5_0000, IDT_LOAD precedes FLUSH.
- iEXE_VALID held with neither flag -> oEXE_LOCK stays 0, registers unchanged. Back-to-back PSR writes -> second write is applied only after the first write's flush ack.
